mem_arbiter: RTL and testbench

Two-master arbiter that shares the processor's single memory port between the CPU core (master 0) and a second bus master such as a program loader or DMA engine (master 1). It sits between the core's memory signals and the memory. It grants the port with round-robin fairness, registers the winning command, and sequences reads against a fixed memory read latency. It returns read data to the granted master with a one-cycle valid pulse.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU core (master 0) and a
// second bus master (master 1). Round-robin arbitration, one command in
// flight at a time, fixed-latency read sequencing, registered outputs.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // WAIT lasts RD_LATENCY cycles, so the counter starts one below it.
  localparam logic [1:0] CNT_LOAD = 2'(RD_LATENCY - 1);

  state_t          state;
  state_t          state_nxt;
  logic            sel;      // master owning the command in flight
  logic            cmd_we;   // command in flight is a write
  logic            last;     // master granted most recently
  logic [1:0]      cnt;
  logic            any_req;
  logic            win;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wd;

  // Winner selection: a lone requester wins; on contention the master not granted last wins.
  always_comb begin
    any_req  = m0_req | m1_req;
    win      = m1_req & (~m0_req | ~last);
    win_we   = win ? m1_we   : m0_we;
    win_addr = win ? m1_addr : m0_addr;
    win_wd   = win ? m1_wd   : m0_wd;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: writes take IDLE->ISSUE->IDLE, reads add RD_LATENCY WAIT cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmd_we ? IDLE : WAIT;
      WAIT:    if (cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, memory port drive, latency counter and read-data return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel       <= 1'b0;
      cmd_we    <= 1'b0;
      last      <= 1'b1;
      cnt       <= 2'd0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rd     <= '0;
      m1_rd     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel      <= win;
            cmd_we   <= win_we;
            last     <= win;
            mem_addr <= win_addr;
            mem_wd   <= win_wd;
            mem_we   <= win_we;
            m0_gnt   <= ~win;
            m1_gnt   <= win;
          end
        end
        ISSUE: begin
          if (!cmd_we) cnt <= CNT_LOAD;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (sel) begin
              m1_rd     <= mem_rd;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rd     <= mem_rd;
              m0_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (read latency 1 and 3) driven by
// queued master operations, checked every cycle against a transaction-level
// model that predicts grant, port and read-return cycles arithmetically.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          m0_req[2], m1_req[2], m0_we[2], m1_we[2];
  logic [AW-1:0] m0_addr[2], m1_addr[2], mem_addr[2];
  logic [DW-1:0] m0_wd[2], m1_wd[2], m0_rd[2], m1_rd[2], mem_wd[2], mem_rd[2];
  logic          m0_gnt[2], m1_gnt[2], m0_rvalid[2], m1_rvalid[2], mem_we[2];

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wd(m0_wd[0]),
    .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rd(m0_rd[0]),
    .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wd(m1_wd[0]),
    .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rd(m1_rd[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wd(m0_wd[1]),
    .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rd(m0_rd[1]),
    .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wd(m1_wd[1]),
    .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rd(m1_rd[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (32'(i) * 32'h00010101);
  endfunction

  // Memory per lane: reloaded while reset is low, read through a delay line.
  logic [DW-1:0] dmem[2][64];
  logic [DW-1:0] pipe[2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int i = 0; i < 64; i++) dmem[k][i] <= init_val(i);
      end else if (mem_we[k]) begin
        dmem[k][mem_addr[k][7:2]] <= mem_wd[k];
      end
      pipe[k][0] <= dmem[k][mem_addr[k][7:2]];
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end
  assign mem_rd[0] = pipe[0][0];
  assign mem_rd[1] = pipe[1][2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model state (per lane), expressed in absolute cycle numbers.
  int          cyc = 0;
  int          lat[2] = '{1, 3};
  int          free_at[2], issue_at[2], rv_at[2];
  bit          last_m[2], isel[2], iwe[2], rvsel[2];
  logic [31:0] iaddr[2], iwd[2], eaddr[2], ewd[2], rvdata[2];
  logic [31:0] erd[2][2];
  logic [31:0] mmem[2][64];
  logic [1:0]  sg[2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic r0, r1;
      bit   w, at_issue, at_rv;
      r0 = m0_req[k];
      r1 = m1_req[k];
      if (!reset) begin
        last_m[k] = 1'b1; free_at[k] = cyc + 1; issue_at[k] = -1; rv_at[k] = -1;
        eaddr[k] = '0; ewd[k] = '0; erd[k][0] = '0; erd[k][1] = '0;
        for (int i = 0; i < 64; i++) mmem[k][i] = init_val(i);
      end else begin
        if (cyc == issue_at[k]) begin
          eaddr[k] = iaddr[k];
          ewd[k]   = iwd[k];
          if (iwe[k]) mmem[k][iaddr[k][7:2]] = iwd[k];
        end
        if (cyc == rv_at[k]) erd[k][rvsel[k]] = rvdata[k];
      end
      at_issue = (cyc == issue_at[k]);
      at_rv    = (cyc == rv_at[k]);
      check($sformatf("L%0d_gnt", lat[k]), {62'd0, m1_gnt[k], m0_gnt[k]},
            {62'd0, at_issue && isel[k], at_issue && !isel[k]});
      check($sformatf("L%0d_rvalid", lat[k]), {62'd0, m1_rvalid[k], m0_rvalid[k]},
            {62'd0, at_rv && rvsel[k], at_rv && !rvsel[k]});
      check($sformatf("L%0d_mem_we", lat[k]), 64'(mem_we[k]), 64'(at_issue && iwe[k]));
      check($sformatf("L%0d_mem_addr", lat[k]), 64'(mem_addr[k]), 64'(eaddr[k]));
      check($sformatf("L%0d_mem_wd", lat[k]), 64'(mem_wd[k]), 64'(ewd[k]));
      check($sformatf("L%0d_m0_rd", lat[k]), 64'(m0_rd[k]), 64'(erd[k][0]));
      check($sformatf("L%0d_m1_rd", lat[k]), 64'(m1_rd[k]), 64'(erd[k][1]));
      if (reset && cyc >= free_at[k] && (r0 || r1)) begin
        if (r0 && r1) w = !last_m[k];
        else          w = r1;
        last_m[k]   = w;
        isel[k]     = w;
        iwe[k]      = w ? m1_we[k]   : m0_we[k];
        iaddr[k]    = w ? m1_addr[k] : m0_addr[k];
        iwd[k]      = w ? m1_wd[k]   : m0_wd[k];
        issue_at[k] = cyc + 1;
        if (iwe[k]) begin
          free_at[k] = cyc + 2;
        end else begin
          free_at[k] = cyc + 2 + lat[k];
          rv_at[k]   = cyc + 2 + lat[k];
          rvsel[k]   = w;
          rvdata[k]  = mmem[k][iaddr[k][7:2]];
        end
      end
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      for (int k = 0; k < 2; k++) sg[k] = {m1_gnt[k], m0_gnt[k]};
      cyc++;
    end
  end

  // Master drivers: index lane*2+master.
  op_t opq[4][$];
  bit  random_mode = 1'b0;

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        int   i;
        logic rq, g;
        op_t  op;
        i  = k * 2 + m;
        rq = (m == 0) ? m0_req[k] : m1_req[k];
        g  = (m == 0) ? sg[k][0] : sg[k][1];
        if (!reset) begin
          opq[i].delete();
          rq = 1'b0;
        end else begin
          if (rq && g) rq = 1'b0;
          if (random_mode && opq[i].size() == 0 && $urandom_range(3) == 0) begin
            op.we   = 1'($urandom_range(1));
            op.addr = {24'h0, 6'($urandom_range(63)), 2'b00};
            op.wd   = $urandom;
            opq[i].push_back(op);
          end
          if (!rq && opq[i].size() != 0) begin
            op = opq[i].pop_front();
            rq = 1'b1;
            if (m == 0) begin
              m0_we[k] = op.we; m0_addr[k] = op.addr; m0_wd[k] = op.wd;
            end else begin
              m1_we[k] = op.we; m1_addr[k] = op.addr; m1_wd[k] = op.wd;
            end
          end
        end
        if (m == 0) m0_req[k] = rq;
        else        m1_req[k] = rq;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic push(input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
    op_t op;
    op.we = we; op.addr = a; op.wd = d;
    for (int k = 0; k < 2; k++) opq[k * 2 + m].push_back(op);
  endtask

  task automatic wait_quiet();
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 200) begin
      step(1);
      n++;
      busy = 1'b0;
      for (int k = 0; k < 2; k++)
        if (opq[k*2].size() != 0 || opq[k*2+1].size() != 0 || m0_req[k] || m1_req[k] ||
            cyc <= free_at[k] || cyc <= rv_at[k]) busy = 1'b1;
    end
    check("quiet_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m0_req[k] = 0; m1_req[k] = 0; m0_we[k] = 0; m1_we[k] = 0;
      m0_addr[k] = '0; m1_addr[k] = '0; m0_wd[k] = '0; m1_wd[k] = '0;
      sg[k] = 2'b00;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step(2);

    // Single read of 0x40 by m0, single write of 0x100 by m1.
    push(0, 1'b0, 32'h40, 32'h0);
    wait_quiet();
    push(1, 1'b1, 32'h100, 32'h12345678);
    wait_quiet();

    // Contention: both masters with several queued accesses.
    for (int j = 0; j < 4; j++) begin
      push(0, j[0], 32'(j * 8), 32'h1000 + 32'(j));
      push(1, ~j[0], 32'(j * 8 + 4), 32'h2000 + 32'(j));
    end
    wait_quiet();

    // m1 request raised while m0's read is waiting on memory.
    push(0, 1'b0, 32'h40, 32'h0);
    step(3);
    push(1, 1'b0, 32'h0, 32'h0);
    wait_quiet();

    // Reset during WAIT of a read.
    push(0, 1'b0, 32'h40, 32'h0);
    step(2);
    @(posedge clk);
    #1 reset = 1'b0;
    drive();
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("L%0d_rst_imm", lat[k]),
            {55'd0, m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_we[k],
             |mem_addr[k], |mem_wd[k], |m0_rd[k], |m1_rd[k]}, 64'd0);
    step(2);
    @(posedge clk);
    #1 reset = 1'b1;
    drive();
    push(0, 1'b0, 32'h40, 32'h0);
    wait_quiet();

    // Back-to-back writes by m0.
    for (int j = 0; j < 4; j++) push(0, 1'b1, 32'(j * 4), 32'hC0DE0000 + 32'(j));
    wait_quiet();

    // Randomized traffic with occasional reset pulses.
    random_mode = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(249) == 0) reset = 1'b0;
      drive();
    end
    random_mode = 1'b0;
    if (!reset) begin
      @(posedge clk);
      #1 reset = 1'b1;
    end
    wait_quiet();
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
